// File: rtl/hamming_74_encode_inject.sv
// Hamming(7,4) encoder stage with single-bit fault injection.
// Encodes a 4-bit message into codeword bits [7:1] (parity at 1, 2, 4), optionally
// flips one bit, and presents the result through a one-deep valid/ready register.
// Injection modes: off, one-shot (armed by a trigger), periodic, and walking.
module hamming_74_encode_inject #(
    parameter int INJ_PERIOD = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       inject_mode,
    input  logic [2:0]       inject_idx,
    input  logic             inject_trig,
    output logic [7:1]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_fault,
    output logic [2:0]       out_fault_pos,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] fault_cnt
);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_ONE  = 2'b01,
        MODE_PER  = 2'b10,
        MODE_WALK = 2'b11
    } mode_t;

    typedef enum logic {
        SHOT_IDLE  = 1'b0,
        SHOT_ARMED = 1'b1
    } shot_t;

    // Last value of the period counter; the word accepted at this count is corrupted.
    localparam logic [7:0] PER_LAST = 8'(INJ_PERIOD - 1);

    mode_t      mode;
    shot_t      shot_state;
    shot_t      shot_next;
    logic       accept;
    logic [7:1] enc;
    logic [2:0] flip_pos;
    logic       do_flip;
    logic [7:1] flip_mask;
    logic [7:0] per_cnt;
    logic       per_last;
    logic [2:0] walk_idx;

    // Codeword layout: data at 3,5,6,7; each parity covers positions whose index has its bit set.
    function automatic logic [7:1] encode(input logic [3:0] d);
        logic [7:1] c;
        c    = '0;
        c[3] = d[0];
        c[5] = d[1];
        c[6] = d[2];
        c[7] = d[3];
        c[1] = c[3] ^ c[5] ^ c[7];
        c[2] = c[3] ^ c[6] ^ c[7];
        c[4] = c[5] ^ c[6] ^ c[7];
        return c;
    endfunction

    assign mode      = mode_t'(inject_mode);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign enc       = encode(in_data);
    assign per_last  = (per_cnt == PER_LAST);
    // A zero position means "no flip", so any non-zero 3-bit position is a legal 1..7.
    assign do_flip   = (flip_pos != 3'd0);
    assign flip_mask = do_flip ? (7'd1 << (flip_pos - 3'd1)) : 7'd0;

    // Select which bit (if any) the word accepted this cycle gets flipped at.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        flip_pos = 3'd0;
        case (mode)
            MODE_ONE:  if (shot_state == SHOT_ARMED) flip_pos = inject_idx;
            MODE_PER:  if (per_last) flip_pos = inject_idx;
            MODE_WALK: flip_pos = walk_idx;
            default:   flip_pos = 3'd0;
        endcase
    end

    // One-shot next state: trigger arms from idle, the next accept disarms; leaving the mode disarms.
    always_comb begin
        shot_next = shot_state;
        if (mode != MODE_ONE) begin
            shot_next = SHOT_IDLE;
        end else begin
            case (shot_state)
                SHOT_IDLE:  if (inject_trig) shot_next = SHOT_ARMED;
                SHOT_ARMED: if (accept) shot_next = SHOT_IDLE;
                default:    shot_next = SHOT_IDLE;
            endcase
        end
    end

    // One-shot state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) shot_state <= SHOT_IDLE;
        else        shot_state <= shot_next;
    end

    // Output register: load on accept, release when drained, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_fault     <= 1'b0;
            out_fault_pos <= 3'd0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_data      <= enc ^ flip_mask;
            out_fault     <= do_flip;
            out_fault_pos <= flip_pos;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

    // Saturating word and fault counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt  <= '0;
            fault_cnt <= '0;
        end else if (accept) begin
            if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
            if (do_flip && fault_cnt != '1) fault_cnt <= fault_cnt + 1'b1;
        end
    end

    // Period counter: counts accepts in periodic mode, wraps after the corrupted word, idles at 0 otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_cnt <= 8'd0;
        end else if (mode != MODE_PER) begin
            per_cnt <= 8'd0;
        end else if (accept) begin
            per_cnt <= per_last ? 8'd0 : per_cnt + 8'd1;
        end
    end

    // Walking position: advances 1..7 per accept in walking mode, holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            walk_idx <= 3'd1;
        end else if (accept && mode == MODE_WALK) begin
            walk_idx <= (walk_idx == 3'd7) ? 3'd1 : walk_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_hamming_74_encode_inject.sv
// Bench for hamming_74_encode_inject: vector table, directed injection sequences,
// a randomized run against a behavioural model, and a counter-saturation instance.
module tb_hamming_74_encode_inject;

    localparam int PERIOD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  inject_mode;
    logic [2:0]  inject_idx;
    logic        inject_trig;
    logic [7:1]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_fault;
    logic [2:0]  out_fault_pos;
    logic [15:0] word_cnt;
    logic [15:0] fault_cnt;

    // Small-counter instance for saturation
    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:1]  s_out_data;
    logic        s_out_valid;
    logic        s_out_fault;
    logic [2:0]  s_out_fault_pos;
    logic [2:0]  s_word_cnt;
    logic [2:0]  s_fault_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hamming_74_encode_inject #(.INJ_PERIOD(PERIOD), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .inject_mode(inject_mode), .inject_idx(inject_idx), .inject_trig(inject_trig),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_fault(out_fault),
        .out_fault_pos(out_fault_pos), .word_cnt(word_cnt), .fault_cnt(fault_cnt)
    );

    hamming_74_encode_inject #(.INJ_PERIOD(1), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_data(4'h0), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .inject_mode(2'b10), .inject_idx(3'd7), .inject_trig(1'b0),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(1'b1), .out_fault(s_out_fault),
        .out_fault_pos(s_out_fault_pos), .word_cnt(s_word_cnt), .fault_cnt(s_fault_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Generic Hamming placement: data fills non-power-of-two positions in order,
    // parity at 2^k is the XOR of all other positions whose index has bit k set.
    function automatic logic [6:0] model_encode(input logic [3:0] d);
        int         data_pos[4];
        logic [6:0] cw;
        logic       par;
        data_pos = '{3, 5, 6, 7};
        cw = '0;
        for (int i = 0; i < 4; i++) if (d[i]) cw[data_pos[i]-1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            par = 1'b0;
            for (int j = 1; j <= 7; j++)
                if (((j & (1 << k)) != 0) && (j != (1 << k))) par ^= cw[j-1];
            cw[(1 << k) - 1] = par;
        end
        return cw;
    endfunction

    // Syndrome decoder: XOR of the indices of set bits names the flipped position.
    function automatic logic [3:0] model_decode(input logic [6:0] cw_in);
        logic [6:0] cw;
        int         syn;
        cw  = cw_in;
        syn = 0;
        for (int j = 1; j <= 7; j++) if (cw[j-1]) syn ^= j;
        if (syn != 0) cw[syn-1] = ~cw[syn-1];
        return {cw[6], cw[5], cw[4], cw[2]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; inject_trig = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Send one word with out_ready=1 and check the registered result one edge later.
    task automatic xfer(input logic [3:0] d, input logic [6:0] exp_d, input logic exp_f,
                        input logic [2:0] exp_p, input string name);
        @(negedge clk);
        in_data = d; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check(name, {out_valid, out_data, out_fault, out_fault_pos}, {1'b1, exp_d, exp_f, exp_p});
    endtask

    typedef struct {
        logic [3:0] d;
        logic [6:0] cw;
    } vec_t;

    vec_t vecs[16];

    // Behavioural model state
    bit         m_valid;
    logic [6:0] m_data;
    bit         m_fault;
    int         m_pos;
    int         m_word;
    int         m_fcnt;
    bit         m_armed;
    int         m_per;
    int         m_walk;

    initial begin
        vecs = '{'{4'h0, 7'h00}, '{4'h1, 7'h07}, '{4'h2, 7'h19}, '{4'h3, 7'h1E},
                 '{4'h4, 7'h2A}, '{4'h5, 7'h2D}, '{4'h6, 7'h33}, '{4'h7, 7'h34},
                 '{4'h8, 7'h4B}, '{4'h9, 7'h4C}, '{4'hA, 7'h52}, '{4'hB, 7'h55},
                 '{4'hC, 7'h61}, '{4'hD, 7'h66}, '{4'hE, 7'h78}, '{4'hF, 7'h7F}};

        rst_n = 1'b0; in_data = 4'h0; in_valid = 1'b0; inject_mode = 2'b00;
        inject_idx = 3'd0; inject_trig = 1'b0; out_ready = 1'b1; s_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {out_valid, out_data, out_fault, out_fault_pos, word_cnt, fault_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic encode of 4'hB
        xfer(4'hB, 7'h55, 1'b0, 3'd0, "enc_B");
        check("word_cnt_1", word_cnt, 64'd1);

        // Mode 00 sweep: table codeword and round trip through decoder model
        for (int i = 0; i < 16; i++) begin
            xfer(vecs[i].d, vecs[i].cw, 1'b0, 3'd0, $sformatf("sweep_%0h", vecs[i].d));
            check($sformatf("decode_%0h", vecs[i].d), model_decode(out_data), vecs[i].d);
        end
        check("sweep_no_faults", fault_cnt, 64'd0);

        // Mode 01 one-shot
        do_reset();
        inject_mode = 2'b01; inject_idx = 3'd3;
        @(negedge clk); inject_trig = 1'b1;
        @(negedge clk); inject_trig = 1'b0;
        xfer(4'hB, 7'h51, 1'b1, 3'd3, "oneshot_hit");
        xfer(4'hB, 7'h55, 1'b0, 3'd0, "oneshot_after");
        check("oneshot_fcnt", fault_cnt, 64'd1);

        // Trigger in the same cycle as an accept arms only; the next word is flipped
        @(negedge clk);
        inject_trig = 1'b1; in_data = 4'h0; in_valid = 1'b1;
        @(posedge clk); #1;
        inject_trig = 1'b0; in_valid = 1'b0;
        check("trig_accept_same", {out_data, out_fault}, {7'h00, 1'b0});
        xfer(4'h0, 7'h04, 1'b1, 3'd3, "trig_accept_next");

        // Mode 10 periodic, PERIOD=4: words 4 and 8 flipped at bit 1
        do_reset();
        inject_mode = 2'b10; inject_idx = 3'd1;
        for (int w = 1; w <= 8; w++) begin
            if (w % PERIOD == 0) xfer(4'h0, 7'h01, 1'b1, 3'd1, $sformatf("periodic_%0d", w));
            else                 xfer(4'h0, 7'h00, 1'b0, 3'd0, $sformatf("periodic_%0d", w));
        end
        check("periodic_fcnt", fault_cnt, 64'd2);

        // Mode 11 walking
        do_reset();
        inject_mode = 2'b11; inject_idx = 3'd0;
        for (int i = 0; i < 9; i++) begin
            int p;
            p = (i % 7) + 1;
            xfer(4'h0, 7'(1 << (p - 1)), 1'b1, 3'(p), $sformatf("walk_%0d", i));
        end
        check("walk_cnts", {word_cnt, fault_cnt}, {16'd9, 16'd9});

        // Stall, change mode under backpressure, then reset mid-stall
        do_reset();
        inject_mode = 2'b00;
        @(negedge clk);
        in_data = 4'h5; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        check("stall_load", {out_valid, out_data}, {1'b1, 7'h2D});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            inject_mode = 2'b11; inject_idx = 3'($urandom_range(1, 7)); in_data = 4'($urandom);
            #1;
            check("stall_in_ready", in_ready, 64'd0);
            @(posedge clk); #1;
            check("stall_hold", {out_valid, out_data, out_fault, out_fault_pos}, {1'b1, 7'h2D, 1'b0, 3'd0});
        end
        check("stall_word_cnt", word_cnt, 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("stall_reset", {out_valid, word_cnt, fault_cnt}, 64'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run against the behavioural model
        do_reset();
        m_valid = 0; m_data = '0; m_fault = 0; m_pos = 0; m_word = 0; m_fcnt = 0;
        m_armed = 0; m_per = 0; m_walk = 1;
        inject_mode = 2'b01;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit acc;
            int fp;
            @(negedge clk);
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            in_data     = 4'($urandom);
            inject_idx  = 3'($urandom);
            inject_trig = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 15) == 0) inject_mode = 2'($urandom);
            #1;
            check("rand_in_ready", in_ready, 64'(!m_valid || out_ready));

            acc = in_valid && (!m_valid || out_ready);
            fp  = 0;
            if (acc) begin
                case (inject_mode)
                    2'b01: if (m_armed) fp = inject_idx;
                    2'b10: begin
                        if (m_per == PERIOD - 1) begin fp = inject_idx; m_per = 0; end
                        else m_per++;
                    end
                    2'b11: begin
                        fp = m_walk;
                        m_walk = (m_walk == 7) ? 1 : m_walk + 1;
                    end
                    default: fp = 0;
                endcase
            end
            if (inject_mode != 2'b10) m_per = 0;
            if (inject_mode != 2'b01) m_armed = 0;
            else if (m_armed)         begin if (acc) m_armed = 0; end
            else if (inject_trig)     m_armed = 1;
            if (acc) begin
                m_valid = 1;
                m_data  = model_encode(in_data) ^ ((fp != 0) ? 7'(1 << (fp - 1)) : 7'd0);
                m_fault = (fp != 0);
                m_pos   = fp;
                m_word++;
                if (fp != 0) m_fcnt++;
            end else if (out_ready) begin
                m_valid = 0;
            end

            @(posedge clk); #1;
            check("rand_valid", out_valid, 64'(m_valid));
            if (m_valid)
                check("rand_word", {out_data, out_fault, out_fault_pos}, {m_data, m_fault, 3'(m_pos)});
            check("rand_cnts", {word_cnt, fault_cnt}, {16'(m_word), 16'(m_fcnt)});
        end
        @(negedge clk);
        in_valid = 1'b0; inject_trig = 1'b0;

        // Saturation: 3-bit counters, every word flipped at bit 7
        @(negedge clk);
        s_in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("sat_cnts", {s_word_cnt, s_fault_cnt}, {3'd7, 3'd7});
        check("sat_word", {s_out_valid, s_out_data, s_out_fault, s_out_fault_pos, s_in_ready},
              {1'b1, 7'h40, 1'b1, 3'd7, 1'b1});
        s_in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
